// File: rtl/pcileech_sysctl.sv
// System control: power-on reset, debounced buttons with press/long-press
// detection, free-running 64-bit tick counter and power-on LED blink overlay.
module pcileech_sysctl #(
  parameter int NUM_BTN          = 2,
  parameter int NUM_LED          = 2,
  parameter int RST_BTN_IDX      = 1,
  parameter int CFG_BTN_IDX      = 1,
  parameter int POR_CYCLES       = 64,
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int LONGPRESS_CYCLES = 500000000,
  parameter int BLINK_BIT        = 24,
  parameter int BLINK_END_BIT    = 27,
  parameter logic [NUM_LED-1:0] BLINK_MASK = NUM_LED'(2'b10)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic [NUM_LED-1:0] led_src,
  input  logic [NUM_LED-1:0] led_invert,
  output logic [NUM_LED-1:0] led_out,
  output logic               rst_sys,
  output logic               rst_cfg_reload,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [63:0]        tickcount64
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int HOLD_W = ($clog2(LONGPRESS_CYCLES) > 32) ? $clog2(LONGPRESS_CYCLES) : 32;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} press_state_t;

  logic [NUM_BTN-1:0] sync1_reg;
  logic [NUM_BTN-1:0] sync2_reg;
  logic [NUM_BTN-1:0] btn_sync;
  logic [NUM_BTN-1:0] in_long;
  logic [63:0]        tick_reg;
  logic               rst_sys_reg;
  logic               cfg_reload_reg;
  logic [NUM_LED-1:0] led_reg;
  logic               blink;

  // Synchroniser flops idle at 1 so reset looks like "all buttons released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= btn_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign btn_sync = ~sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      logic [DB_W-1:0]   db_cnt_reg;
      logic              state_reg;
      logic              state_d_reg;
      logic              press_reg;
      logic              release_reg;
      logic              long_reg;
      logic              long_next;
      press_state_t      fsm_reg;
      press_state_t      fsm_next;
      logic [HOLD_W-1:0] hold_reg;
      logic [HOLD_W-1:0] hold_next;

      always_ff @(posedge clk) begin
        if (rst) begin
          db_cnt_reg  <= '0;
          state_reg   <= 1'b0;
          state_d_reg <= 1'b0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          long_reg    <= 1'b0;
          fsm_reg     <= IDLE;
          hold_reg    <= '0;
        end else begin
          if (btn_sync[gi] == state_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg  <= ~state_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
          state_d_reg <= state_reg;
          press_reg   <= state_reg & ~state_d_reg;
          release_reg <= ~state_reg & state_d_reg;
          fsm_reg     <= fsm_next;
          hold_reg    <= hold_next;
          long_reg    <= long_next;
        end
      end

      // Hold counter counts cycles with btn_state high; entry into HELD is the first.
      always_comb begin
        fsm_next  = fsm_reg;
        hold_next = hold_reg;
        long_next = 1'b0;
        case (fsm_reg)
          IDLE: begin
            if (state_reg) begin
              fsm_next  = HELD;
              hold_next = HOLD_W'(1);
            end
          end
          HELD: begin
            if (!state_reg) begin
              fsm_next  = IDLE;
              hold_next = '0;
            end else if (hold_reg == HOLD_LAST) begin
              fsm_next  = LONG;
              long_next = 1'b1;
            end else begin
              hold_next = hold_reg + 1'b1;
            end
          end
          LONG: begin
            if (!state_reg) begin
              fsm_next  = IDLE;
              hold_next = '0;
            end
          end
          default: begin
            fsm_next  = IDLE;
            hold_next = '0;
          end
        endcase
      end

      assign btn_state[gi]   = state_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_long[gi]    = long_reg;
      assign in_long[gi]     = (fsm_reg == LONG);
    end
  endgenerate

  assign blink = tick_reg[BLINK_BIT] & ((tick_reg >> BLINK_END_BIT) == 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg       <= '0;
      rst_sys_reg    <= 1'b1;
      cfg_reload_reg <= 1'b0;
      led_reg        <= '0;
    end else begin
      tick_reg       <= btn_state[RST_BTN_IDX] ? 64'd0 : tick_reg + 64'd1;
      rst_sys_reg    <= btn_state[RST_BTN_IDX] | (tick_reg < 64'(POR_CYCLES));
      cfg_reload_reg <= in_long[CFG_BTN_IDX];
      led_reg        <= led_src ^ led_invert ^ (BLINK_MASK & {NUM_LED{blink}});
    end
  end

  assign tickcount64    = tick_reg;
  assign rst_sys        = rst_sys_reg;
  assign rst_cfg_reload = cfg_reload_reg;
  assign led_out        = led_reg;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Directed bench for pcileech_sysctl with short debounce/long-press/blink timing.
module tb_pcileech_sysctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn_n;
  logic [1:0]  led_src;
  logic [1:0]  led_invert;
  logic [1:0]  led_out;
  logic        rst_sys;
  logic        rst_cfg_reload;
  logic [1:0]  btn_state;
  logic [1:0]  btn_press;
  logic [1:0]  btn_release;
  logic [1:0]  btn_long;
  logic [63:0] tickcount64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcileech_sysctl #(
    .NUM_BTN(2), .NUM_LED(2), .RST_BTN_IDX(1), .CFG_BTN_IDX(1),
    .POR_CYCLES(8), .DEBOUNCE_CYCLES(4), .LONGPRESS_CYCLES(20),
    .BLINK_BIT(2), .BLINK_END_BIT(5), .BLINK_MASK(2'b10)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .led_src(led_src),
    .led_invert(led_invert), .led_out(led_out), .rst_sys(rst_sys),
    .rst_cfg_reload(rst_cfg_reload), .btn_state(btn_state),
    .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long),
    .tickcount64(tickcount64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    btn_n      = 2'b11;
    led_src    = 2'b00;
    led_invert = 2'b00;
    repeat (3) step();
    chk64("reset_tick", tickcount64, 64'd0);
    chk1("reset_rst_sys", rst_sys, 1'b1);
    chk1("reset_cfg", rst_cfg_reload, 1'b0);
    chk1("reset_btn", |{btn_state, btn_press, btn_release, btn_long}, 1'b0);
    chk1("reset_led", |led_out, 1'b0);
    $display("reset: tick=%0d rst_sys=%0b", tickcount64, rst_sys);

    // Power-on: rst_sys holds while tick < 8; LED1 blinks on tick bit 2 until tick 32.
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk64("por_tick", tickcount64, 64'(k));
      chk1("por_rst_sys", rst_sys, k <= 8);
      chk1("blink_led1", led_out[1], ((((k - 1) >> 2) & 1) == 1) && ((k - 1) < 32));
      chk1("blink_led0", led_out[0], 1'b0);
    end
    $display("power-on: tick=%0d rst_sys=%0b led=%b", tickcount64, rst_sys, led_out);

    led_invert = 2'b01;
    step();
    chk1("invert_led0", led_out[0], 1'b1);
    chk1("invert_led1", led_out[1], 1'b0);
    led_invert = 2'b00;
    step();
    chk1("uninvert_led0", led_out[0], 1'b0);
    $display("led invert: led=%b", led_out);

    // Clean press and release of button 0.
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk1("press0_state", btn_state[0], k >= 6);
      chk1("press0_pulse", btn_press[0], k == 7);
      chk1("press0_long", btn_long[0], 1'b0);
      chk1("press0_rst_sys", rst_sys, 1'b0);
    end
    btn_n[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk1("rel0_state", btn_state[0], k < 6);
      chk1("rel0_pulse", btn_release[0], k == 7);
      chk1("rel0_press", btn_press[0], 1'b0);
    end
    $display("clean press/release btn0: state=%b", btn_state);

    // Bounce: low 3, high 1, then low stable; one press timed from the last edge.
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk1("bounce_state", btn_state[0], k >= 10);
      chk1("bounce_press", btn_press[0], k == 11);
      chk1("bounce_release", btn_release[0], 1'b0);
      if (k == 3) btn_n[0] = 1'b1;
      if (k == 4) btn_n[0] = 1'b0;
    end
    btn_n[0] = 1'b1;
    repeat (8) step();
    chk1("bounce_released", btn_state[0], 1'b0);
    $display("bounce btn0: state=%b", btn_state);

    // Long hold of button 1 (reset + cfg button).
    btn_n[1] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk1("hold1_state", btn_state[1], (k >= 6) && (k < 46));
      chk1("hold1_press", btn_press[1], k == 7);
      chk1("hold1_release", btn_release[1], k == 47);
      chk1("hold1_long", btn_long[1], k == 26);
      chk1("hold1_cfg", rst_cfg_reload, (k >= 27) && (k <= 47));
      chk1("hold1_rst_sys", rst_sys, (k >= 7) && (k <= 54));
      chk1("hold1_long0", btn_long[0], 1'b0);
      if (k >= 7) chk64("hold1_tick", tickcount64, (k <= 46) ? 64'd0 : 64'(k - 46));
      if (k == 40) btn_n[1] = 1'b1;
    end
    $display("long hold btn1: rst_sys=%0b cfg=%0b tick=%0d", rst_sys, rst_cfg_reload, tickcount64);

    // rst while button 0 is in long-press; held button must re-debounce afterwards.
    btn_n[0] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk1("pre_rst_long0", btn_long[0], k == 26);
    end
    rst = 1'b1;
    for (int k = 31; k <= 62; k++) begin
      step();
      if (k <= 32) begin
        chk64("midrst_tick", tickcount64, 64'd0);
        chk1("midrst_rst_sys", rst_sys, 1'b1);
        chk1("midrst_led", |led_out, 1'b0);
        chk1("midrst_cfg", rst_cfg_reload, 1'b0);
      end
      chk1("midrst_state0", btn_state[0], k >= 38);
      chk1("midrst_press0", btn_press[0], k == 39);
      chk1("midrst_long0", btn_long[0], k == 58);
      chk1("midrst_state1", btn_state[1], 1'b0);
      if (k == 32) rst = 1'b0;
    end
    btn_n[0] = 1'b1;
    repeat (4) step();
    $display("rst mid-press btn0: state=%b", btn_state);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcileech_sysctl.md
Name: pcileech_sysctl

Overview:
- Parametrised system-control block: power-on reset generation, N-button debounce with press/long-press detection, free-running 64-bit tick counter, power-on LED blink overlay for M LEDs.
- Replaces the ad-hoc tickcount/reset/blink logic in the per-board top modules; instantiated once per top, in the clk (100 MHz) domain.
- Feeds rst to pcileech_com / pcileech_fifo / pcileech_pcie_a7, rst_cfg_reload to pcileech_fifo, and LED pads.

Parameters:
- NUM_BTN, 2, number of active-low push buttons (1..8).
- NUM_LED, 2, number of LED outputs (1..8).
- RST_BTN_IDX, 1, index of the button that forces system reset.
- CFG_BTN_IDX, 1, index of the button whose long press drives cfg reload.
- POR_CYCLES, 64, cycles rst_sys stays high after tick restart (>=1).
- DEBOUNCE_CYCLES, 1000000, cycles a synchronised level must be stable to be accepted (>=1).
- LONGPRESS_CYCLES, 500000000, debounced-held cycles before long-press (> DEBOUNCE_CYCLES).
- BLINK_BIT, 24, tick bit used as blink square wave.
- BLINK_END_BIT, 27, blinking active while tick[63:BLINK_END_BIT]==0.
- BLINK_MASK, 2'b10, per-LED enable of the blink overlay (NUM_LED bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_n  in  NUM_BTN  raw asynchronous buttons, active-low.
- led_src  in  NUM_LED  LED state from consumers.
- led_invert  in  NUM_LED  static per-LED inversion (user switch).
- led_out  out  NUM_LED  registered LED drive.
- rst_sys  out  1  system reset to downstream blocks, active-high.
- rst_cfg_reload  out  1  level, high while CFG button held past LONGPRESS_CYCLES.
- btn_state  out  NUM_BTN  debounced pressed state (1 = pressed).
- btn_press  out  NUM_BTN  one-cycle pulse on debounced press.
- btn_release  out  NUM_BTN  one-cycle pulse on debounced release.
- btn_long  out  NUM_BTN  one-cycle pulse when long-press threshold reached.
- tickcount64  out  64  cycles since last reset/reset-button release.

Behaviour:
- Reset (rst=1): tickcount64=0, rst_sys=1, rst_cfg_reload=0, btn_state/press/release/long=0, led_out=0, debounce and hold counters=0, synchroniser flops=1 (released).
- Synchroniser: btn_n passes 2 flops, then inverted -> btn_sync. Latency raw->btn_sync 2 cycles.
- Debounce per button: counter clears whenever btn_sync==btn_state; otherwise increments; when it reaches DEBOUNCE_CYCLES-1 while still differing, btn_state toggles next cycle and counter clears. A bounce (btn_sync returns to btn_state) restarts count. Press latency from clean edge: 2 + DEBOUNCE_CYCLES cycles.
- btn_press/btn_release: registered edge of btn_state, asserted in the cycle after btn_state changes, exactly one cycle.
- Per-button FSM: IDLE (btn_state=0) -> HELD on press; HELD: hold counter (saturating, 32-bit min) increments each cycle; when it reaches LONGPRESS_CYCLES-1 -> LONG with btn_long pulse one cycle; HELD/LONG -> IDLE on release, hold counter cleared. Never re-pulses btn_long within one press.
- rst_cfg_reload = (FSM[CFG_BTN_IDX]==LONG), registered.
- tickcount64: cleared while rst or btn_state[RST_BTN_IDX]; else increments by 1 per cycle, wraps 2^64-1 -> 0 (no other effect).
- rst_sys registered: 1 when rst, btn_state[RST_BTN_IDX], or tickcount64 < POR_CYCLES; so after reset button release rst_sys stays high POR_CYCLES+1 cycles.
- Blink term = tick[BLINK_BIT] & (tick[63:BLINK_END_BIT]==0). led_out[i] (registered, 1 cycle) = led_src[i] ^ led_invert[i] ^ (BLINK_MASK[i] & blink). After tick passes 2^BLINK_END_BIT, overlay permanently off (until tick restart, including wrap).
- RST_BTN_IDX==CFG_BTN_IDX is legal: holding that button resets system and eventually asserts cfg reload; rst_sys and rst_cfg_reload both high.
- Simultaneous press on multiple buttons: independent, no priority.
- rst mid-press: all button state cleared; a still-held button re-debounces after rst deasserts and must press again through full debounce (new btn_press pulse).

Test Plan (sim params: DEBOUNCE_CYCLES=4, POR_CYCLES=8, LONGPRESS_CYCLES=20, BLINK_BIT=2, BLINK_END_BIT=5):
- rst high 3 cycles then low, buttons released -> rst_sys high through tick 0..7, low from cycle where tick==8 (+1 reg), tickcount64 counts 1 per cycle.
- btn_n[0] low clean -> btn_state[0] rises 6 cycles later, btn_press[0] one-cycle pulse next cycle; release -> btn_release[0] pulse after 6 cycles.
- btn_n[0] bounces low 3 cycles / high 1 / low stable -> single btn_press, timed from last stable edge; no glitch pulses.
- Hold btn 1 for 40 cycles -> rst_sys high and tick=0 while held, btn_long[1] single pulse 20 cycles after btn_state rose, rst_cfg_reload high until release; after release rst_sys low after 9 cycles.
- LED: led_src=0, led_invert=0, BLINK_MASK=2'b10 -> led_out[1] toggles every 4 cycles while tick<32, then constant 0; led_out[0] stays 0; led_invert[0]=1 -> led_out[0]=1 one cycle later.
- rst asserted while btn 0 held in LONG -> outputs cleared same edge; after rst low, btn_press[0] re-pulses after 6 cycles, btn_long after 20 more.
